// File: rtl/cpu_pkg.sv
// Shared types for the accumulator teaching CPU: opcodes, control states and ALU selects.
package cpu_pkg;

    localparam int unsigned OPCODE_W = 3;

    typedef enum logic [OPCODE_W-1:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DECODE  = 2'd1,
        EXECUTE = 2'd2,
        HALTED  = 2'd3
    } state_t;

    localparam logic [1:0] ACC_PASS = 2'd0;
    localparam logic [1:0] ACC_ADD  = 2'd1;
    localparam logic [1:0] ACC_AND  = 2'd2;
    localparam logic [1:0] ACC_XOR  = 2'd3;

endpackage

// File: rtl/cpu_accumulator.sv
// Accumulator register with its ALU (pass / add / and / xor against the MDR operand).
module cpu_accumulator
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [1:0]        ctrl,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] data_out
);
    logic [DATA_W-1:0] alu_result;

    always_comb begin
        alu_result = operand;
        case (ctrl)
            ACC_PASS: alu_result = operand;
            ACC_ADD:  alu_result = data_out + operand;
            ACC_AND:  alu_result = data_out & operand;
            ACC_XOR:  alu_result = data_out ^ operand;
            default:  alu_result = operand;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
        end else if (load) begin
            data_out <= alu_result;
        end
    end

endmodule

// File: rtl/cpu_control.sv
// Control unit: FETCH/DECODE/EXECUTE sequencer plus combinational decode of state and opcode.
module cpu_control
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  opcode_t    opcode,
    input  logic       acc_zero,
    output logic       pc_load,
    output logic       pc_en,
    output logic       halt,
    output logic       jmp,
    output logic [1:0] accumulator_control,
    output logic       accumulator_load,
    output logic       memIns_en,
    output logic       memDa_en,
    output logic       memDa_we
);
    state_t state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            unique case (state)
                FETCH:   state <= DECODE;
                DECODE:  state <= EXECUTE;
                EXECUTE: state <= (opcode == HLT) ? HALTED : FETCH;
                HALTED:  state <= HALTED;
            endcase
        end
    end

    always_comb begin
        pc_load             = 1'b0;
        pc_en               = 1'b0;
        halt                = 1'b0;
        jmp                 = 1'b0;
        accumulator_control = ACC_PASS;
        accumulator_load    = 1'b0;
        memIns_en           = 1'b0;
        memDa_en            = 1'b0;
        memDa_we            = 1'b0;
        // Everything stays quiet while reset is held.
        if (!rst) begin
            unique case (state)
                FETCH: memIns_en = 1'b1;
                DECODE: begin
                    pc_en    = 1'b1;
                    memDa_en = 1'b1;
                end
                EXECUTE: begin
                    unique case (opcode)
                        HLT: halt = 1'b1;
                        SKZ: pc_en = acc_zero;
                        ADD: begin
                            accumulator_control = ACC_ADD;
                            accumulator_load    = 1'b1;
                        end
                        AND: begin
                            accumulator_control = ACC_AND;
                            accumulator_load    = 1'b1;
                        end
                        XOR: begin
                            accumulator_control = ACC_XOR;
                            accumulator_load    = 1'b1;
                        end
                        LDA: begin
                            accumulator_control = ACC_PASS;
                            accumulator_load    = 1'b1;
                        end
                        STO: begin
                            memDa_en = 1'b1;
                            memDa_we = 1'b1;
                        end
                        JMP: begin
                            jmp     = 1'b1;
                            pc_load = 1'b1;
                        end
                    endcase
                end
                HALTED: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/cpu_mem.sv
// Word-addressed memory array; combinational read, registered downstream into IR/MDR.
module cpu_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    // Contents are intentionally not reset; the program is preloaded.
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/combinational_logic.sv
// Accumulator CPU core. Define CPU_DEBUG_PORTS_EN to expose acc_out and pc_out.
module combinational_logic
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    output logic              HALT
`ifdef CPU_DEBUG_PORTS_EN
    ,
    output logic [DATA_W-1:0] acc_out,
    output logic [ADDR_W-1:0] pc_out
`endif
);
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] ins_rdata;
    logic [DATA_W-1:0] dat_rdata;
    logic [ADDR_W-1:0] imm;
    opcode_t           opcode;

    logic       pc_load;
    logic       pc_en;
    logic       halt;
    logic       jmp;
    logic [1:0] accumulator_control;
    logic       accumulator_load;
    logic       memIns_en;
    logic       memDa_en;
    logic       memDa_we;

    assign opcode = opcode_t'(ir[DATA_W-1 -: OPCODE_W]);
    assign imm    = ir[ADDR_W-1:0];

    cpu_control control_signal (
        .clk                 (clk),
        .rst                 (rst),
        .opcode              (opcode),
        .acc_zero            (acc == '0),
        .pc_load             (pc_load),
        .pc_en               (pc_en),
        .halt                (halt),
        .jmp                 (jmp),
        .accumulator_control (accumulator_control),
        .accumulator_load    (accumulator_load),
        .memIns_en           (memIns_en),
        .memDa_en            (memDa_en),
        .memDa_we            (memDa_we)
    );

    cpu_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) MemIns (
        .clk   (clk),
        .en    (memIns_en),
        .we    (1'b0),
        .addr  (pc),
        .wdata ('0),
        .rdata (ins_rdata)
    );

    cpu_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) MemData (
        .clk   (clk),
        .en    (memDa_en),
        .we    (memDa_we),
        .addr  (imm),
        .wdata (acc),
        .rdata (dat_rdata)
    );

    cpu_accumulator #(.DATA_W(DATA_W)) accumulator (
        .clk      (clk),
        .rst      (rst),
        .load     (accumulator_load),
        .ctrl     (accumulator_control),
        .operand  (mdr),
        .data_out (acc)
    );

    // jmp picks the target; pc_load / pc_en decide whether the PC moves at all.
    assign pc_next = jmp ? imm : pc + ADDR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc   <= '0;
            ir   <= '0;
            mdr  <= '0;
            HALT <= 1'b0;
        end else begin
            if (pc_load || pc_en) begin
                pc <= pc_next;
            end
            if (memIns_en) begin
                ir <= ins_rdata;
            end
            if (memDa_en && !memDa_we) begin
                mdr <= dat_rdata;
            end
            if (halt) begin
                HALT <= 1'b1;
            end
        end
    end

`ifdef CPU_DEBUG_PORTS_EN
    assign acc_out = acc;
    assign pc_out  = pc;
`endif

endmodule

// File: tb/tb_combinational_logic.sv
// Self-checking bench for the accumulator CPU: directed cases plus random programs vs a model.
module tb_combinational_logic;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic HALT;

    int n_checks = 0;
    int n_errors = 0;

    // Instruction-level reference model.
    logic [7:0] m_imem [32];
    logic [7:0] m_dmem [32];
    logic [7:0] m_acc;
    logic [4:0] m_pc;
    logic       m_halt;

    combinational_logic dut (
        .clk  (clk),
        .rst  (rst),
        .HALT (HALT)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ins(input int op, input int imm);
        logic [2:0] o;
        logic [4:0] a;
        o = op[2:0];
        a = imm[4:0];
        return {o, a};
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) begin
            m_imem[i] = 8'h00;
            m_dmem[i] = 8'h00;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Async reset at an arbitrary point, preload memories, release on a falling edge.
    task automatic start_run();
        rst = 1'b1;
        #2;
        check("rst_halt", {31'd0, HALT}, 32'd0);
        check("rst_acc", {24'd0, dut.accumulator.data_out}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            dut.MemIns.mem[i]  <= m_imem[i];
            dut.MemData.mem[i] <= m_dmem[i];
        end
        #1;
        m_pc   = 5'd0;
        m_acc  = 8'd0;
        m_halt = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic model_step();
        logic [7:0] w;
        logic [4:0] a;
        if (m_halt) return;
        w    = m_imem[m_pc];
        a    = w[4:0];
        m_pc = m_pc + 5'd1;
        case (w[7:5])
            3'd0: m_halt = 1'b1;
            3'd1: if (m_acc == 8'd0) m_pc = m_pc + 5'd1;
            3'd2: m_acc = m_acc + m_dmem[a];
            3'd3: m_acc = m_acc & m_dmem[a];
            3'd4: m_acc = m_acc ^ m_dmem[a];
            3'd5: m_acc = m_dmem[a];
            3'd6: m_dmem[a] = m_acc;
            default: m_pc = a;
        endcase
    endtask

    logic [7:0] alu_exp [3];

    initial begin
        alu_exp[0] = 8'h2C;
        alu_exp[1] = 8'h30;
        alu_exp[2] = 8'hCC;

        // HLT at address 0: HALT on the 3rd clock and sticky afterwards.
        clear_model();
        m_imem[0] = ins(0, 0);
        start_run();
        tick(2);
        check("hlt_early", {31'd0, HALT}, 32'd0);
        tick(1);
        check("hlt_rise", {31'd0, HALT}, 32'd1);
        tick(4);
        check("hlt_sticky", {31'd0, HALT}, 32'd1);

        // JMP over a second JMP straight to HLT.
        clear_model();
        m_imem[0] = ins(7, 2);
        m_imem[1] = ins(7, 2);
        m_imem[2] = ins(0, 0);
        start_run();
        tick(5);
        check("jmp_early", {31'd0, HALT}, 32'd0);
        tick(1);
        check("jmp_halt", {31'd0, HALT}, 32'd1);

        // SKZ with acc==0 skips the JMP at address 1.
        clear_model();
        m_imem[0] = ins(1, 2);
        m_imem[1] = ins(7, 2);
        m_imem[2] = ins(0, 0);
        m_imem[3] = ins(7, 3);
        start_run();
        tick(5);
        check("skz_early", {31'd0, HALT}, 32'd0);
        tick(1);
        check("skz_halt", {31'd0, HALT}, 32'd1);

        // LDA updates acc on the 3rd clock.
        clear_model();
        m_dmem[5] = 8'd20;
        m_imem[0] = ins(5, 5);
        start_run();
        tick(2);
        check("lda_early", {24'd0, dut.accumulator.data_out}, 32'd0);
        tick(1);
        check("lda_acc", {24'd0, dut.accumulator.data_out}, 32'd20);

        // STO writes only at the close of its EXECUTE.
        clear_model();
        m_dmem[5] = 8'd18;
        m_imem[0] = ins(5, 5);
        m_imem[1] = ins(6, 10);
        start_run();
        tick(5);
        check("sto_early", {24'd0, dut.MemData.mem[10]}, 32'd0);
        tick(1);
        check("sto_mem", {24'd0, dut.MemData.mem[10]}, 32'd18);

        // ALU ops with acc=0xF0 against 0x3C.
        for (int k = 0; k < 3; k++) begin
            clear_model();
            m_dmem[4] = 8'hF0;
            m_dmem[3] = 8'h3C;
            m_imem[0] = ins(5, 4);
            m_imem[1] = ins(2 + k, 3);
            start_run();
            tick(6);
            check($sformatf("alu_op%0d", 2 + k), {24'd0, dut.accumulator.data_out},
                  {24'd0, alu_exp[k]});
        end

        // Random programs, each started with a reset wherever the previous run was.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 32; i++) begin
                int op;
                op = $urandom_range(0, 7);
                if (op == 0 && $urandom_range(0, 5) != 0) op = $urandom_range(1, 7);
                m_imem[i] = ins(op, $urandom_range(0, 31));
                m_dmem[i] = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 3) == 0) m_dmem[i] = 8'd0;
            end
            start_run();
            for (int s = 0; s < 40; s++) begin
                tick(3);
                model_step();
                check($sformatf("rnd%0d_s%0d_acc", r, s), {24'd0, dut.accumulator.data_out},
                      {24'd0, m_acc});
                check($sformatf("rnd%0d_s%0d_halt", r, s), {31'd0, HALT}, {31'd0, m_halt});
            end
            for (int i = 0; i < 32; i++) begin
                check($sformatf("rnd%0d_dmem%0d", r, i), {24'd0, dut.MemData.mem[i]},
                      {24'd0, m_dmem[i]});
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
